stream_eq_checker: RTL
======================

STREAM_EQ_CHECKER -- requirements
Module: stream_eq_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stream data width.
REQ-002 SHALL have parameter DEPTH, default 8, per-side FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CNT_W, default 16, token counter / length width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, max idle RUN cycles without a compare.
REQ-005 SHALL have parameter STOP_ON_MISMATCH, default 1, 1 = enter FAIL on first mismatch.
REQ-006 SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port ap_rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port init  in  1  synchronous run start/restart pulse.
REQ-009 SHALL have port expected_len  in  CNT_W  tokens to compare per run, sampled on init.
REQ-010 SHALL have ports ila_complete, hls_complete  in  1  per-design instruction-complete flags.
REQ-011 SHALL have ports ila_step_en, hls_step_en  out  1  registered clock enables for the two designs.
REQ-012 SHALL have ports ila_TDATA / hls_TDATA  in  DATA_W  captured output streams.
REQ-013 SHALL have ports ila_TVALID / hls_TVALID  in  1  and ila_TREADY / hls_TREADY  out  1.
REQ-014 SHALL have ports done, pass, mismatch, timeout, excess  out  1  status.
REQ-015 SHALL have ports match_cnt, mm_idx  out  CNT_W  and mm_ila_data, mm_hls_data  out  DATA_W.

Function
REQ-016 SHALL implement states IDLE, PRIME, RUN, DONE, FAIL.
REQ-017 SHALL go to PRIME on init from any state, latching expected_len, clearing FIFOs, counters, sticky flags.
REQ-018 SHALL hold PRIME exactly one cycle, then go to RUN, or to DONE if latched length = 0.
REQ-019 SHALL register step enables: 0 in IDLE/DONE/FAIL; 1 for both in PRIME; ~x_complete in RUN.
REQ-020 SHALL drive x_TREADY = ~fifo_x_full in PRIME/RUN, 1 in DONE, 0 in IDLE/FAIL; push on TVALID & TREADY.
REQ-021 SHALL pop both FIFOs together in RUN when both non-empty; pop and push on the same cycle are legal, no bypass when full.
REQ-022 SHALL compare FIFO heads on pop; equal -> match_cnt+1 registered the following cycle.
REQ-023 SHALL on unequal heads set mismatch (sticky), record mm_idx = compare index, mm_ila_data, mm_hls_data (first mismatch only).
REQ-024 SHALL go to FAIL after a mismatch if STOP_ON_MISMATCH=1; otherwise continue counting to expected_len.
REQ-025 SHALL go to DONE when compare count reaches latched expected_len; done=1 in DONE.
REQ-026 SHALL count RUN cycles without a pop, clear on pop; reaching TIMEOUT sets timeout and goes to FAIL.
REQ-027 SHALL in DONE accept and drop tokens; any accepted token sets excess (sticky).
REQ-028 SHALL drive pass = done & ~mismatch & ~excess.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH with an extra bit for full/empty; counters SHALL NOT wrap (saturate at all-ones).
REQ-030 SHALL give init priority over every simultaneous event (compare, timeout, push).

Reset
REQ-031 SHALL on ap_rst_n low asynchronously force IDLE, FIFOs empty, all outputs and counters 0, step enables 0, TREADY 0.
REQ-032 SHALL resume only on init after reset release; reset mid-run discards all captured data.

Verification
REQ-033 Verify: init, len=4, both sides send 0x11,0x22,0x33,0x44 with 3-cycle HLS lag -> done=1, pass=1, match_cnt=4.
REQ-034 Verify: len=3, HLS second token 0x23 vs ILA 0x22 -> mismatch=1, mm_idx=1, mm_ila_data=0x22, mm_hls_data=0x23, FAIL, step enables 0.
REQ-035 Verify: DEPTH=8, ILA sends 9 tokens, HLS silent -> ila_TREADY=0 after 8 pushes; HLS silent TIMEOUT cycles -> timeout=1, FAIL.
REQ-036 Verify: len=2, three tokens per side -> done=1, excess=1, pass=0.
REQ-037 Verify: init asserted mid-RUN with data queued -> one PRIME cycle with both step enables 1, FIFOs empty, match_cnt=0.
REQ-038 Verify: ap_rst_n low mid-RUN -> immediate IDLE, all outputs 0, no completion until next init.

Source files
------------

// File: rtl/stream_eq_checker.sv
// Lock-step equivalence checker for two captured output streams (ILA model vs HLS design).
// Buffers each side in a small FIFO, compares heads pairwise and reports match/mismatch/timeout/excess.
module stream_eq_checker #(
    parameter int DATA_W           = 8,
    parameter int DEPTH            = 8,
    parameter int CNT_W            = 16,
    parameter int TIMEOUT          = 1024,
    parameter int STOP_ON_MISMATCH = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              init,
    input  logic [CNT_W-1:0]  expected_len,
    input  logic              ila_complete,
    input  logic              hls_complete,
    output logic              ila_step_en,
    output logic              hls_step_en,
    input  logic [DATA_W-1:0] ila_TDATA,
    input  logic              ila_TVALID,
    output logic              ila_TREADY,
    input  logic [DATA_W-1:0] hls_TDATA,
    input  logic              hls_TVALID,
    output logic              hls_TREADY,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic              timeout,
    output logic              excess,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  mm_idx,
    output logic [DATA_W-1:0] mm_ila_data,
    output logic [DATA_W-1:0] mm_hls_data
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, PRIME, RUN, DONE, FAIL} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] ila_mem [DEPTH];
    logic [DATA_W-1:0] hls_mem [DEPTH];
    logic [AW:0]       ila_wr_ptr, ila_rd_ptr, hls_wr_ptr, hls_rd_ptr;
    logic              ila_empty, ila_full, hls_empty, hls_full;
    logic              in_capture, ila_acc, hls_acc, ila_push, hls_push;
    logic              pop, heads_eq, timeout_hit;
    logic [DATA_W-1:0] ila_head, hls_head;
    logic [CNT_W-1:0]  len_q, cmp_cnt, cmp_inc;
    logic [TO_W-1:0]   idle_cnt;

    assign ila_empty = (ila_wr_ptr == ila_rd_ptr);
    assign hls_empty = (hls_wr_ptr == hls_rd_ptr);
    assign ila_full  = (ila_wr_ptr[AW] != ila_rd_ptr[AW]) &&
                       (ila_wr_ptr[AW-1:0] == ila_rd_ptr[AW-1:0]);
    assign hls_full  = (hls_wr_ptr[AW] != hls_rd_ptr[AW]) &&
                       (hls_wr_ptr[AW-1:0] == hls_rd_ptr[AW-1:0]);

    assign ila_head = ila_mem[ila_rd_ptr[AW-1:0]];
    assign hls_head = hls_mem[hls_rd_ptr[AW-1:0]];
    assign heads_eq = (ila_head == hls_head);

    assign in_capture = (state == PRIME) || (state == RUN);

    always_comb begin
        ila_TREADY = 1'b0;
        hls_TREADY = 1'b0;
        case (state)
            PRIME, RUN: begin
                ila_TREADY = ~ila_full;
                hls_TREADY = ~hls_full;
            end
            DONE: begin
                ila_TREADY = 1'b1;
                hls_TREADY = 1'b1;
            end
            default: ;
        endcase
    end

    // A restart pulse wins over any handshake, compare or timeout on the same edge.
    assign ila_acc     = ila_TVALID & ila_TREADY;
    assign hls_acc     = hls_TVALID & hls_TREADY;
    assign ila_push    = ila_acc & in_capture & ~init;
    assign hls_push    = hls_acc & in_capture & ~init;
    assign pop         = (state == RUN) & ~ila_empty & ~hls_empty & ~init;
    assign timeout_hit = (state == RUN) & ~pop & (idle_cnt == TO_LAST) & ~init;
    assign cmp_inc     = (cmp_cnt == '1) ? cmp_cnt : cmp_cnt + CNT_ONE;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PRIME: state_next = (len_q == '0) ? DONE : RUN;
            RUN: begin
                if (pop) begin
                    if (!heads_eq && (STOP_ON_MISMATCH != 0)) begin
                        state_next = FAIL;
                    end else if (cmp_inc == len_q) begin
                        state_next = DONE;
                    end
                end else if (timeout_hit) begin
                    state_next = FAIL;
                end
            end
            default: ;
        endcase
        if (init) begin
            state_next = PRIME;
        end
    end

    // Enables are registered off the next state so they line up with the state they belong to.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ila_step_en <= 1'b0;
            hls_step_en <= 1'b0;
        end else begin
            case (state_next)
                PRIME: begin
                    ila_step_en <= 1'b1;
                    hls_step_en <= 1'b1;
                end
                RUN: begin
                    ila_step_en <= ~ila_complete;
                    hls_step_en <= ~hls_complete;
                end
                default: begin
                    ila_step_en <= 1'b0;
                    hls_step_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ila_push) begin
            ila_mem[ila_wr_ptr[AW-1:0]] <= ila_TDATA;
        end
        if (hls_push) begin
            hls_mem[hls_wr_ptr[AW-1:0]] <= hls_TDATA;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ila_wr_ptr <= '0;
            ila_rd_ptr <= '0;
            hls_wr_ptr <= '0;
            hls_rd_ptr <= '0;
        end else if (init) begin
            ila_wr_ptr <= '0;
            ila_rd_ptr <= '0;
            hls_wr_ptr <= '0;
            hls_rd_ptr <= '0;
        end else begin
            if (ila_push) begin
                ila_wr_ptr <= ila_wr_ptr + PTR_ONE;
            end
            if (hls_push) begin
                hls_wr_ptr <= hls_wr_ptr + PTR_ONE;
            end
            if (pop) begin
                ila_rd_ptr <= ila_rd_ptr + PTR_ONE;
                hls_rd_ptr <= hls_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            len_q       <= '0;
            cmp_cnt     <= '0;
            match_cnt   <= '0;
            idle_cnt    <= '0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            excess      <= 1'b0;
            mm_idx      <= '0;
            mm_ila_data <= '0;
            mm_hls_data <= '0;
        end else if (init) begin
            len_q       <= expected_len;
            cmp_cnt     <= '0;
            match_cnt   <= '0;
            idle_cnt    <= '0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            excess      <= 1'b0;
            mm_idx      <= '0;
            mm_ila_data <= '0;
            mm_hls_data <= '0;
        end else begin
            if (pop) begin
                cmp_cnt  <= cmp_inc;
                idle_cnt <= '0;
                if (heads_eq) begin
                    if (match_cnt != '1) begin
                        match_cnt <= match_cnt + CNT_ONE;
                    end
                end else if (!mismatch) begin
                    mismatch    <= 1'b1;
                    mm_idx      <= cmp_cnt;
                    mm_ila_data <= ila_head;
                    mm_hls_data <= hls_head;
                end
            end else if ((state == RUN) && (idle_cnt != '1)) begin
                idle_cnt <= idle_cnt + TO_ONE;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
            if ((state == DONE) && (ila_acc || hls_acc)) begin
                excess <= 1'b1;
            end
        end
    end

    assign done = (state == DONE);
    assign pass = done & ~mismatch & ~excess;

endmodule
